// File: rtl/ioblock_bank.sv
// Bank of WIDTH programmable I/O pins. Per-pin configuration arrives on a serial
// scan chain and is committed atomically once a full frame has been shifted in.
module ioblock_bank #(
    parameter int WIDTH = 4
) (
    input  logic             IOCLK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] TS,
    input  logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] IN,
    input  logic             CFG_EN,
    input  logic             CFG_DIN,
    output logic             CFG_DOUT,
    output logic             CFG_DONE,
    output logic             CFG_ERR
);

    localparam int L  = 5 * WIDTH;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ABORT
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            shift_en;
    logic [L-1:0]    shadow_reg;
    logic [L-1:0]    active_reg;

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            active_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (shift_en) begin
                shadow_reg <= {CFG_DIN, shadow_reg[L-1:1]};
            end
            // Pins only ever see a completely loaded frame.
            if (state_reg == COMMIT) begin
                active_reg <= shadow_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (CFG_EN) begin
                    shift_en   = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (CFG_EN) begin
                    shift_en = 1'b1;
                    if (cnt_reg == CW'(L - 1)) begin
                        cnt_next   = '0;
                        state_next = COMMIT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = ABORT;
                end
            end
            COMMIT:  state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign CFG_DOUT = shadow_reg[0];
    assign CFG_DONE = (state_reg == COMMIT);
    assign CFG_ERR  = (state_reg == ABORT);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            logic [1:0] tsmux;
            logic       dorreg;
            logic       oreg;
            logic       treg;
            logic       oe_raw;
            logic       oe;
            logic       dout;
            logic       oe_q_reg;
            logic       dout_q_reg;
            logic       d_reg;

            assign tsmux  = active_reg[5*gi+3 +: 2];
            assign dorreg = active_reg[5*gi+2];
            assign oreg   = active_reg[5*gi+1];
            assign treg   = active_reg[5*gi];

            always_comb begin
                case (tsmux)
                    2'b00:   oe_raw = 1'b0;
                    2'b01:   oe_raw = TS[gi];
                    2'b10:   oe_raw = ~TS[gi];
                    default: oe_raw = 1'b1;
                endcase
            end

            // Flops capture unconditionally so enabling one never exposes stale data.
            always_ff @(posedge IOCLK) begin
                if (RST) begin
                    oe_q_reg   <= 1'b0;
                    dout_q_reg <= 1'b0;
                    d_reg      <= 1'b0;
                end else begin
                    oe_q_reg   <= oe_raw;
                    dout_q_reg <= OUT[gi];
                    d_reg      <= PIN[gi];
                end
            end

            assign oe      = treg ? oe_q_reg : oe_raw;
            assign dout    = oreg ? dout_q_reg : OUT[gi];
            assign PIN[gi] = oe ? dout : 1'bz;
            assign IN[gi]  = dorreg ? d_reg : PIN[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ioblock_bank.sv
// Bench for ioblock_bank: a behavioural model checked every cycle, plus
// hand-computed expectations for the reset, load, mode and abort scenarios.
module tb_ioblock_bank;

    localparam int W = 4;
    localparam int L = 5 * W;

    logic         clk = 1'b0;
    logic         rst;
    wire  [W-1:0] pin;
    logic [W-1:0] ts;
    logic [W-1:0] out_v;
    logic [W-1:0] in_v;
    logic         cfg_en;
    logic         cfg_din;
    logic         cfg_dout;
    logic         cfg_done;
    logic         cfg_err;
    logic [W-1:0] ext_val;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ioblock_bank #(.WIDTH(W)) dut (
        .IOCLK   (clk),
        .RST     (rst),
        .PIN     (pin),
        .TS      (ts),
        .OUT     (out_v),
        .IN      (in_v),
        .CFG_EN  (cfg_en),
        .CFG_DIN (cfg_din),
        .CFG_DOUT(cfg_dout),
        .CFG_DONE(cfg_done),
        .CFG_ERR (cfg_err)
    );

    // Model state: committed configuration, one-cycle-old copies, frame progress.
    logic [L-1:0] m_active = '0;
    logic [W-1:0] m_oeq    = '0;
    logic [W-1:0] m_outq   = '0;
    logic [W-1:0] m_d      = '0;
    int           m_cnt    = 0;
    bit           m_done   = 1'b0;
    bit           m_err    = 1'b0;
    bit           m_hist[$];

    logic [W-1:0] m_raw_now;
    logic [W-1:0] m_oe_now;
    logic [W-1:0] e_pin, e_in, e_dv;

    function automatic logic [W-1:0] raw_of(input logic [L-1:0] act, input logic [W-1:0] t);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (act[5*i+3 +: 2])
                2'b00:   r[i] = 1'b0;
                2'b01:   r[i] = t[i];
                2'b10:   r[i] = ~t[i];
                default: r[i] = 1'b1;
            endcase
        end
        return r;
    endfunction

    // Shadow bit j is the bit that was shifted in L-1-j shifts ago.
    function automatic logic shadow_bit(input int j);
        if (m_hist.size() > L - 1 - j) return m_hist[L-1-j];
        return 1'b0;
    endfunction

    always_comb begin
        m_raw_now = raw_of(m_active, ts);
        m_oe_now  = '0;
        for (int i = 0; i < W; i++) begin
            m_oe_now[i] = m_active[5*i] ? m_oeq[i] : m_raw_now[i];
        end
    end

    // The bench drives each pad exactly when the model says the DUT must not.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_ext
            assign pin[gi] = m_oe_now[gi] ? 1'bz : ext_val[gi];
        end
    endgenerate

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < W; i++) begin
            e_dv[i]  = m_active[5*i+1] ? m_outq[i] : out_v[i];
            e_pin[i] = m_oe_now[i] ? e_dv[i] : ext_val[i];
            e_in[i]  = m_active[5*i+2] ? m_d[i] : e_pin[i];
        end
        check("model_pin", 32'(pin), 32'(e_pin));
        check("model_in", 32'(in_v), 32'(e_in));
        check("model_dout", 32'(cfg_dout), 32'(shadow_bit(0)));
        check("model_done", 32'(cfg_done), 32'(m_done));
        check("model_err", 32'(cfg_err), 32'(m_err));
        $display("cyc t=%0t en=%b din=%b ts=%b out=%b pin=%b in=%b dout=%b done=%b err=%b",
                 $time, cfg_en, cfg_din, ts, out_v, pin, in_v, cfg_dout, cfg_done, cfg_err);
        if (rst) begin
            m_active = '0;
            m_oeq    = '0;
            m_outq   = '0;
            m_d      = '0;
            m_cnt    = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_hist.delete();
        end else begin
            m_d    = e_pin;
            m_outq = out_v;
            m_oeq  = m_raw_now;
            if (m_done) begin
                for (int j = 0; j < L; j++) m_active[j] = shadow_bit(j);
                m_done = 1'b0;
            end else if (m_err) begin
                m_err = 1'b0;
            end else if (cfg_en) begin
                m_hist.push_front(cfg_din);
                if (m_hist.size() > L) void'(m_hist.pop_back());
                m_cnt++;
                if (m_cnt == L) begin
                    m_done = 1'b1;
                    m_cnt  = 0;
                end
            end else if (m_cnt > 0) begin
                m_err = 1'b1;
                m_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [L-1:0] f);
        for (int i = 0; i < L; i++) begin
            cfg_en  = 1'b1;
            cfg_din = f[i];
            step();
        end
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    logic [L-1:0] fa, fb;

    initial begin
        rst = 1'b1; cfg_en = 1'b1; cfg_din = 1'b0;
        ts = '0; out_v = 4'b1111; ext_val = 4'b1010;

        // Reset: pads released, IN follows the externally forced pattern
        @(negedge clk);
        check("rst_pin", 32'(pin), 32'h0000_000a);
        check("rst_in", 32'(in_v), 32'h0000_000a);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        step();
        @(negedge clk);
        check("rst_in2", 32'(in_v), 32'h0000_000a);
        step();
        rst = 1'b0; cfg_en = 1'b0;
        step();

        // Full load: every pin always driven, no registers
        out_v = 4'b0110; ext_val = 4'b1001;
        send_frame({4{5'b11000}});
        @(negedge clk);
        check("load_done", 32'(cfg_done), 32'd1);
        check("load_pin_z", 32'(pin), 32'h0000_0009);
        step();
        @(negedge clk);
        check("load_pin", 32'(pin), 32'h0000_0006);
        check("load_in", 32'(in_v), 32'h0000_0006);
        check("load_done_off", 32'(cfg_done), 32'd0);

        // TS modes: pin0 follows TS, pin1 follows ~TS
        step();
        ts = 4'b0011; out_v = 4'b0011; ext_val = 4'b0000;
        send_frame({5'b00000, 5'b00000, 5'b10000, 5'b01000});
        step();
        @(negedge clk);
        check("ts_mode_a", 32'(pin), 32'h0000_0001);
        step();
        ts = 4'b0000;
        @(negedge clk);
        check("ts_mode_b", 32'(pin), 32'h0000_0002);

        // Registered paths on pin2
        step();
        out_v = 4'b0000;
        send_frame({5'b00000, 5'b11111, 5'b00000, 5'b00000});
        step();
        step();
        @(negedge clk);
        check("reg_pin_pre", 32'(pin), 32'h0000_0000);
        step();
        out_v = 4'b0100;
        @(negedge clk);
        check("reg_pin_k", 32'(pin), 32'h0000_0000);
        step();
        @(negedge clk);
        check("reg_pin_k1", 32'(pin), 32'h0000_0004);
        check("reg_in_k1", 32'(in_v), 32'h0000_0000);
        step();
        @(negedge clk);
        check("reg_in_k2", 32'(in_v), 32'h0000_0004);

        // Abort after 7 bits, then a clean frame
        step();
        for (int i = 0; i < 7; i++) begin
            cfg_en = 1'b1; cfg_din = 1'b1;
            step();
        end
        cfg_en = 1'b0; cfg_din = 1'b0;
        @(negedge clk);
        check("abort_err_pre", 32'(cfg_err), 32'd0);
        step();
        @(negedge clk);
        check("abort_err", 32'(cfg_err), 32'd1);
        check("abort_done", 32'(cfg_done), 32'd0);
        step();
        @(negedge clk);
        check("abort_err_off", 32'(cfg_err), 32'd0);
        check("abort_pin", 32'(pin), 32'h0000_0004);
        step();
        out_v = 4'b1110;
        send_frame({5'b11010, {3{5'b11000}}});
        @(negedge clk);
        check("reload_done", 32'(cfg_done), 32'd1);
        step();
        @(negedge clk);
        check("reload_pin", 32'(pin), 32'h0000_000e);

        // Back-to-back frames with CFG_EN held high for 42 cycles
        step();
        fa = {4{5'b10001}};
        fb = {4{5'b01000}};
        for (int c = 1; c <= 42; c++) begin
            cfg_en = 1'b1;
            if (c <= 20)                 cfg_din = fa[c-1];
            else if (c >= 22 && c <= 41) cfg_din = fb[c-22];
            else                         cfg_din = 1'b1;
            ts      = W'($urandom);
            out_v   = W'($urandom);
            ext_val = W'($urandom);
            @(negedge clk);
            check("b2b_done", 32'(cfg_done), 32'((c == 21) || (c == 42)));
            if (c == 21 || c == 22) check("b2b_dout_a", 32'(cfg_dout), 32'd1);
            if (c == 42) check("b2b_dout_b", 32'(cfg_dout), 32'd0);
            step();
        end
        cfg_en = 1'b0; cfg_din = 1'b0;
        ts = 4'b1111; out_v = 4'b0101; ext_val = 4'b0000;
        @(negedge clk);
        check("b2b_pin", 32'(pin), 32'h0000_0005);
        step();
        ts = 4'b0011; out_v = 4'b1111; ext_val = 4'b0100;
        @(negedge clk);
        check("b2b_pin2", 32'(pin), 32'h0000_0007);
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
